// File: rtl/cnt_pkg.sv
// -----------------------------------------------------------------------------
// cnt_pkg
// Shared definitions for the timer cluster (cnt, clkdiv, cnt_capture).
//   CNT_UP / CNT_DOWN           : count direction encodings
//   CNT_EDGE_RISE / _FALL       : active-edge selection for capture logic
//   cnt_cap_state_t             : cnt_capture measurement engine states
// -----------------------------------------------------------------------------
package cnt_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  localparam logic CNT_EDGE_RISE = 1'b1;
  localparam logic CNT_EDGE_FALL = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // engine disabled, accumulators held at zero
    ARM  = 2'd1,  // waiting for the first active edge, nothing measured yet
    MEAS = 2'd2   // counting cycles since the last active edge
  } cnt_cap_state_t;

endpackage

// File: rtl/cnt_capture_if.sv
// -----------------------------------------------------------------------------
// cnt_capture_if
// Control/result bundle of the input-capture timer.
//   en      : capture enable (low holds the engine idle)
//   sig     : asynchronous input being measured
//   it_ack  : clears the sticky it/ovf flags
//   period  : last captured period in clk cycles
//   high    : cycles at active level in the last period
//             (present only when CNT_CAPTURE_DUTY_EN is defined)
//   valid   : one-cycle strobe, results updated this cycle
//   it      : sticky capture interrupt
//   ovf     : sticky period-counter saturation flag
// Modports: master = the block driving/consuming (bench, CPU side),
//           slave  = cnt_capture itself.
// -----------------------------------------------------------------------------
interface cnt_capture_if #(
  parameter int width = 32
);

  logic             en;
  logic             sig;
  logic             it_ack;
  logic [width-1:0] period;
`ifdef CNT_CAPTURE_DUTY_EN
  logic [width-1:0] high;
`endif
  logic             valid;
  logic             it;
  logic             ovf;

  modport master (
    output en, sig, it_ack,
    input  period, valid, it, ovf
`ifdef CNT_CAPTURE_DUTY_EN
    , input high
`endif
  );

  modport slave (
    input  en, sig, it_ack,
    output period, valid, it, ovf
`ifdef CNT_CAPTURE_DUTY_EN
    , output high
`endif
  );

endinterface

// File: rtl/cnt_sync_edge.sv
// -----------------------------------------------------------------------------
// cnt_sync_edge
// Three-flop synchronizer for an asynchronous input plus active-edge detect.
// Parameter:
//   active_edge : CNT_EDGE_RISE (1) or CNT_EDGE_FALL (0)
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   d        : asynchronous input
//   lvl      : synchronized level (third flop)
//   e        : one-cycle active-edge pulse, derived from flops two and three
// -----------------------------------------------------------------------------
module cnt_sync_edge
  import cnt_pkg::*;
#(
  parameter logic active_edge = CNT_EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic e
);

  logic s1, s2, s3;

  // NOTE: clocked state is always written with non-blocking (<=) so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the three stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s1 may be metastable; only s2/s3 are used downstream.
  assign lvl = s3;
  assign e   = (active_edge == CNT_EDGE_RISE) ? (s2 & ~s3) : (~s2 & s3);

endmodule

// File: rtl/cnt_capture.sv
// -----------------------------------------------------------------------------
// cnt_capture
// Input-capture timer: measures, in clk cycles, the period between successive
// active edges of an asynchronous signal and publishes each result with a
// one-cycle valid strobe plus a sticky interrupt. A saturated period counter
// raises a sticky ovf flag and the next edge reports all-ones.
// Optional feature macro: CNT_CAPTURE_DUTY_EN -- also measures the number of
// cycles spent at the active level in each period (the 'high' output).
// Parameters:
//   width       : width of the period/high counters and outputs
//   active_edge : CNT_EDGE_RISE (1) or CNT_EDGE_FALL (0)
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : cnt_capture_if.slave (en, sig, it_ack in; period, high, valid,
//          it, ovf out)
// -----------------------------------------------------------------------------
module cnt_capture
  import cnt_pkg::*;
#(
  parameter int   width       = 32,
  parameter logic active_edge = CNT_EDGE_RISE
) (
  input logic          clk,
  input logic          rst,
  cnt_capture_if.slave bus
);

  localparam logic [width-1:0] all_ones = '1;
  localparam logic [width-1:0] one      = width'(1);

  cnt_cap_state_t   state_q, state_d;
  logic             lvl, e;
  logic             capture, ovf_set;
  logic [width-1:0] acc, acc_next;
  logic [width-1:0] period_q;
  logic             valid_q, it_q, ovf_q;

  cnt_sync_edge #(
    .active_edge(active_edge)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.sig),
    .lvl (lvl),
    .e   (e)
  );

  // NOTE: every variable driven here gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (bus.en) state_d = ARM;
      ARM:  if (e)      state_d = MEAS;
      MEAS: if (e)      capture = 1'b1;
      default:          state_d = IDLE;
    endcase
    // Dropping enable wins from any state and forces a fresh ARM later, so a
    // period spanning a disabled interval is never published.
    if (!bus.en) begin
      state_d = IDLE;
      capture = 1'b0;
    end
  end

  // Accumulator: restarts at 1 on every edge that leaves us in MEAS (the edge
  // cycle itself is the first cycle of the new period), saturates otherwise.
  always_comb begin
    acc_next = '0;
    if (state_d == MEAS) begin
      if (e)                     acc_next = one;
      else if (acc != all_ones)  acc_next = acc + one;
      else                       acc_next = acc;
    end
  end

  assign ovf_set = (state_q == MEAS) && (acc == all_ones);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc      <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      it_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc     <= acc_next;
      valid_q <= capture;
      if (capture) period_q <= acc;
      // Set has priority over a coincident acknowledge.
      it_q  <= capture | (it_q & ~bus.it_ack);
      ovf_q <= ovf_set | (ovf_q & ~bus.it_ack);
    end
  end

  assign bus.period = period_q;
  assign bus.valid  = valid_q;
  assign bus.it     = it_q;
  assign bus.ovf    = ovf_q;

`ifdef CNT_CAPTURE_DUTY_EN
  logic [width-1:0] hacc, high_q;

  // hacc counts synchronized active-level cycles between captures; the
  // capture cycle itself starts a new period and is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hacc   <= '0;
      high_q <= '0;
    end else begin
      if (capture) high_q <= hacc;
      if ((state_d != MEAS) || e) begin
        hacc <= '0;
      end else if ((lvl == active_edge) && (hacc != all_ones)) begin
        hacc <= hacc + one;
      end
    end
  end

  assign bus.high = high_q;
`else
  logic unused_lvl;
  assign unused_lvl = lvl;
`endif

endmodule
